// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the multicycle ALU: mode encoding,
//                flag bit positions and the handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operation select encoding (mode input)
  localparam logic [3:0] MODE_ADD   = 4'h0;
  localparam logic [3:0] MODE_ADC   = 4'h1;
  localparam logic [3:0] MODE_SUB   = 4'h2;
  localparam logic [3:0] MODE_SBB   = 4'h3;
  localparam logic [3:0] MODE_AND   = 4'h4;
  localparam logic [3:0] MODE_OR    = 4'h5;
  localparam logic [3:0] MODE_XOR   = 4'h6;
  localparam logic [3:0] MODE_NOT   = 4'h7;
  localparam logic [3:0] MODE_SHL   = 4'h8;
  localparam logic [3:0] MODE_SHR   = 4'h9;
  localparam logic [3:0] MODE_SAR   = 4'hA;
  localparam logic [3:0] MODE_ROL   = 4'hB;
  localparam logic [3:0] MODE_ROR   = 4'hC;
  localparam logic [3:0] MODE_MULU  = 4'hD;
  localparam logic [3:0] MODE_DIVU  = 4'hE;
  localparam logic [3:0] MODE_PASSB = 4'hF;

  // Bit positions inside the 4-bit {Z,C,S,O} flags bus
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_muldiv
//  Description : Iterative unsigned shift-add multiplier / restoring divider.
//                One product or quotient bit per cycle, WIDTH cycles total.
//                The first iteration is performed on the start edge directly
//                from the a/b inputs, so done rises WIDTH cycles after start.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst_n   clock, asynchronous active-low reset
//    start        load operands and run the first iteration
//    is_div       1 = divide (a / b), 0 = multiply (a * b); sampled at start
//    a, b         operands, sampled at start
//    busy         an operation is in progress
//    done         lo/hi hold the final value (one cycle pulse)
//    lo, hi       MUL: low/high product halves; DIV: quotient/remainder
// ============================================================================
module alu_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  // acc holds the running high product half / partial remainder,
  // lo_acc holds the multiplier bits being consumed / quotient bits produced.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             div_q, div_d;

  logic [WIDTH-1:0] step_acc, step_lo, step_b;
  logic             step_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] nxt_acc, nxt_lo;

  // One iteration of either algorithm; sources come straight from the inputs
  // on the start cycle so no cycle is spent just loading operands.
  always_comb begin
    if (start) begin
      step_acc = '0;
      step_lo  = a;
      step_b   = b;
      step_div = is_div;
    end else begin
      step_acc = acc_q;
      step_lo  = lo_acc_q;
      step_b   = b_q;
      step_div = div_q;
    end

    mul_sum   = {1'b0, step_acc} + (step_lo[0] ? {1'b0, step_b} : '0);
    div_shift = {step_acc, step_lo[WIDTH-1]};

    if (step_div) begin
      // Restoring step: subtract only when the shifted remainder covers b.
      if (div_shift >= {1'b0, step_b}) begin
        nxt_acc = WIDTH'(div_shift - {1'b0, step_b});
        nxt_lo  = {step_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = div_shift[WIDTH-1:0];
        nxt_lo  = {step_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: {acc, lo} = ({acc + b*lo[0], lo}) >> 1
      nxt_acc = mul_sum[WIDTH:1];
      nxt_lo  = {mul_sum[0], step_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d    = acc_q;
    lo_acc_d = lo_acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    div_d    = div_q;
    if (start) begin
      acc_d    = nxt_acc;
      lo_acc_d = nxt_lo;
      b_d      = b;
      div_d    = is_div;
      cnt_d    = CNT_W'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end else begin
        acc_d    = nxt_acc;
        lo_acc_d = nxt_lo;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      lo_acc_q <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      lo_acc_q <= lo_acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      div_q    <= div_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_LAST);
  assign lo   = lo_acc_q;
  assign hi   = acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Registered ALU with valid/ready handshakes on both sides.
//                Single-cycle ops return one cycle after accept; unsigned
//                MUL/DIV run on an iterative unit and return WIDTH+1 cycles
//                after accept.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    in_valid / in_ready   operation request handshake
//    op_a, op_b            operands (op_b low bits = shift amount)
//    mode                  operation select (see alu_pkg MODE_*)
//    carry_in              carry/borrow input for ADC/SBB
//    out_valid / out_ready result handshake
//    result, result_hi     result / MUL high half or DIV remainder
//    flags                 {Z,C,S,O}
// ============================================================================
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int                SH_W   = $clog2(WIDTH);
  localparam logic [SH_W:0]     W_FULL = (SH_W + 1)'(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             is_div_q, is_div_d;

  logic             accept;
  logic             go_iter;
  logic             iter_start;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  // ------------------------------------------------------------------
  // Single-cycle datapath
  // ------------------------------------------------------------------
  logic [SH_W-1:0]  sh;
  logic             sh_nz;
  logic [SH_W:0]    rot_amt;
  logic [WIDTH:0]   add_sum, sub_diff, shl_t, shr_t, sar_t;
  logic [WIDTH-1:0] rol_r, ror_r;
  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_c, sc_o;
  logic [3:0]       sc_flags;

  assign sh      = op_b[SH_W-1:0];
  assign sh_nz   = (sh != '0);
  assign rot_amt = W_FULL - {1'b0, sh};

  always_comb begin
    add_sum  = {1'b0, op_a} + {1'b0, op_b}
             + {{WIDTH{1'b0}}, (mode == MODE_ADC) & carry_in};
    sub_diff = {1'b0, op_a} - {1'b0, op_b}
             - {{WIDTH{1'b0}}, (mode == MODE_SBB) & carry_in};
    // Extra bit on the shifted-out side captures the last bit lost; it is
    // naturally 0 when the shift amount is 0.
    shl_t    = {1'b0, op_a} << sh;
    shr_t    = {op_a, 1'b0} >> sh;
    sar_t    = $signed({op_a, 1'b0}) >>> sh;
    // With sh==0 rot_amt equals WIDTH and the wrap term shifts out to 0.
    rol_r    = (op_a << sh) | (op_a >> rot_amt);
    ror_r    = (op_a >> sh) | (op_a << rot_amt);

    sc_result = op_b;
    sc_hi     = '0;
    sc_c      = 1'b0;
    sc_o      = 1'b0;
    case (mode)
      MODE_ADD, MODE_ADC: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_c      = add_sum[WIDTH];
        sc_o      = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      MODE_SUB, MODE_SBB: begin
        sc_result = sub_diff[WIDTH-1:0];
        sc_c      = ~sub_diff[WIDTH];   // carry set means no borrow
        sc_o      = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      MODE_AND: sc_result = op_a & op_b;
      MODE_OR:  sc_result = op_a | op_b;
      MODE_XOR: sc_result = op_a ^ op_b;
      MODE_NOT: sc_result = ~op_a;
      MODE_SHL: begin
        sc_result = shl_t[WIDTH-1:0];
        sc_c      = shl_t[WIDTH];
      end
      MODE_SHR: begin
        sc_result = shr_t[WIDTH:1];
        sc_c      = shr_t[0];
      end
      MODE_SAR: begin
        sc_result = sar_t[WIDTH:1];
        sc_c      = sar_t[0];
      end
      MODE_ROL: begin
        sc_result = rol_r;
        sc_c      = sh_nz & rol_r[0];
      end
      MODE_ROR: begin
        sc_result = ror_r;
        sc_c      = sh_nz & ror_r[WIDTH-1];
      end
      // Only reached here without the iterative unit: behaves as pass B.
      MODE_MULU: sc_result = op_b;
      MODE_DIVU: begin
        if (MULDIV_EN && (op_b == '0)) begin
          sc_result = '1;
          sc_hi     = op_a;
          sc_c      = 1'b1;
          sc_o      = 1'b1;
        end else begin
          sc_result = op_b;
        end
      end
      MODE_PASSB: sc_result = op_b;
      default:    sc_result = op_b;
    endcase

    sc_flags         = '0;
    sc_flags[FLAG_Z] = (sc_result == '0);
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_S] = sc_result[WIDTH-1];
    sc_flags[FLAG_O] = sc_o;
  end

  // Divide by zero is resolved in the single-cycle path.
  assign go_iter = MULDIV_EN &&
                   ((mode == MODE_MULU) || ((mode == MODE_DIVU) && (op_b != '0)));

  // ------------------------------------------------------------------
  // Iterative multiply / divide unit
  // ------------------------------------------------------------------
  generate
    if (MULDIV_EN) begin : g_muldiv
      alu_iter_muldiv #(
        .WIDTH (WIDTH)
      ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (mode == MODE_DIVU),
        .a      (op_a),
        .b      (op_b),
        .busy   (iter_busy),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
      );
    end else begin : g_no_muldiv
      assign iter_busy = 1'b0;
      assign iter_done = 1'b0;
      assign iter_lo   = '0;
      assign iter_hi   = '0;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Handshake FSM and output registers
  // ------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    is_div_d    = is_div_q;
    iter_start  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (go_iter) begin
            iter_start = 1'b1;
            is_div_d   = (mode == MODE_DIVU);
            state_d    = ST_BUSY;
          end else begin
            result_d    = sc_result;
            result_hi_d = sc_hi;
            flags_d     = sc_flags;
            state_d     = ST_DONE;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          result_d         = iter_lo;
          result_hi_d      = iter_hi;
          flags_d          = '0;
          flags_d[FLAG_Z]  = is_div_q ? (iter_lo == '0) : ({iter_hi, iter_lo} == '0);
          flags_d[FLAG_C]  = !is_div_q && (iter_hi != '0);
          flags_d[FLAG_S]  = iter_lo[WIDTH-1];
          flags_d[FLAG_O]  = !is_div_q && (iter_hi != '0);
          state_d          = ST_DONE;
        end else if (!iter_busy) begin
          // Unit lost its operation (cannot happen in normal flow): recover.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      is_div_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      is_div_q    <= is_div_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire
